gb_instr_feeder: RTL and testbench
==================================

Name: gb_instr_feeder

Overview:
- Upstream stage of gbprocessor: buffers instruction/operand pairs from a producer (sequence driver or program ROM reader) and issues them to the processor on its instruction/data/valid inputs.
- One valid pulse per instruction, with a programmable number of idle cycles between issues so the processor can settle.
- Valid/ready handshake on input; the processor side has no backpressure.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- ISSUE_GAP, 0, idle cycles with valid=0 after each issued instruction; 0..255.
- CNT_W, 16, width of issued_count.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous active-high reset; sampled on the rising edge of clock.
- in_valid  input  1  producer presents an entry.
- in_ready  output  1  feeder can accept; equals !full.
- in_instruction  input  8  opcode byte.
- in_data  input  8  operand byte.
- enable  input  1  issue permission; 0 pauses issuing, buffering continues.
- instruction  output  8  to gbprocessor.instruction.
- data  output  8  to gbprocessor.data.
- valid  output  1  to gbprocessor.valid; high exactly one cycle per issued entry.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- issued_count  output  CNT_W  number of entries issued since reset.

Behaviour:
- Reset, synchronous: FIFO empty, level=0, in_ready=1, valid=0, instruction=8'h00, data=8'h00, issued_count=0, FSM=IDLE, gap counter=0. Reset mid-operation discards all buffered entries and any pending gap. Inputs are ignored during the reset cycle.
- Push: occurs when in_valid && in_ready at the clock edge. in_ready is combinational !full.
  - When full, no push occurs even if a pop happens in the same cycle. No same-cycle refill.
- All outputs toward the processor are registered.
- FSM states:
  - IDLE: if enable && !empty, pop the head, load instruction/data, set valid=1, increment issued_count, go to ISSUE. Otherwise valid=0.
  - ISSUE: valid=0.
    - If ISSUE_GAP==0, behave as IDLE in this same cycle, so back-to-back issues occur on consecutive cycles.
    - Otherwise load gap counter=ISSUE_GAP-1 and go to GAP.
  - GAP: valid=0; decrement the counter each cycle; at 0 go to IDLE. The counter keeps running when enable=0.
- Throughput:
  - ISSUE_GAP=0: one instruction per cycle.
  - Otherwise: one per ISSUE_GAP+2 cycles (one issue cycle, the ISSUE-state cycle, ISSUE_GAP gap cycles). For example, with ISSUE_GAP=3, issues repeat every 5 cycles.
- Latency: an entry pushed at edge N into an empty FIFO, with enable=1 and FSM in IDLE, appears with valid=1 after edge N+1. No bypass path.
- Output hold: instruction/data keep the last issued values while valid=0. Consumers must qualify them with valid.
- Simultaneous push and pop on a non-full FIFO: both occur and level is unchanged.
- enable falling: takes effect at the next issue decision. An issue already registered is not retracted.
- Wrap-around:
  - FIFO pointers wrap modulo DEPTH.
  - issued_count wraps from all-ones to 0 silently.
- level equals pushes minus pops since reset, always in 0..DEPTH.

Decomposition:
- Shared package gb_pkg:
  - ALU op field constants for instruction[5:3]: ADD=0, ADC=1, SUB=2, SBC=3, AND=4, XOR=5, OR=6, CP=7.
  - Register field constants for instruction[2:0]: B=0, C=1, D=2, E=3, H=4, L=5, HL=6, A=7.
  - gb_entry_t packed struct {instruction[7:0], data[7:0]}.
  - The feeder FSM state enum.
- One sub-module, gb_sync_fifo (parameterised DEPTH, width of gb_entry_t). It provides push/pop, full/empty and level, and has the same clock/reset.

Test Plan:
- Reset then idle: after reset, valid=0, instruction=8'h00, data=8'h00, level=0, in_ready=1. With enable=1 and no push for 20 cycles, valid stays 0.
- Single entry latency: push {8'hAB (XOR E), 8'h5A} at edge N with enable=1 and ISSUE_GAP=0 → valid=1 with instruction=8'hAB, data=8'h5A after edge N+1 only; issued_count=1.
- Fill/full: enable=0, push 9 entries with DEPTH=8 → 8 accepted, in_ready=0, level=8. The 9th is held by the producer. Set enable=1 → entries issue in push order, and the 9th is accepted once level=7.
- Gap spacing: ISSUE_GAP=3, push 4 entries (SBC B, XOR C, CP A, SUB E: 8'h98, 8'hA9, 8'hBF, 8'h93) → valid pulses exactly 5 cycles apart, in that order.
- Pause/resume: stream 10 entries, drop enable for 4 cycles after the 3rd issue → no valid pulse during the pause. Issuing resumes with the 4th entry and nothing is lost or duplicated.
- Reset mid-stream: with level=5 and the FSM in GAP, assert reset for one cycle → level=0, valid=0, issued_count=0. A subsequent push issues normally with the standard latency.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared types for the gbprocessor front end: ALU/register field codes,
// the buffered instruction entry and the feeder FSM state encoding.
package gb_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_ADC = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_SBC = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_OR  = 3'd6;
  localparam logic [2:0] ALU_CP  = 3'd7;

  localparam logic [2:0] REG_B  = 3'd0;
  localparam logic [2:0] REG_C  = 3'd1;
  localparam logic [2:0] REG_D  = 3'd2;
  localparam logic [2:0] REG_E  = 3'd3;
  localparam logic [2:0] REG_H  = 3'd4;
  localparam logic [2:0] REG_L  = 3'd5;
  localparam logic [2:0] REG_HL = 3'd6;
  localparam logic [2:0] REG_A  = 3'd7;

  typedef struct packed {
    logic [7:0] instruction;
    logic [7:0] data;
  } gb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } feeder_state_e;

endpackage

// File: rtl/gb_sync_fifo.sv
// Single-clock FIFO of instruction entries with occupancy count.
// Push is refused when full, pop is refused when empty.
module gb_sync_fifo
  import gb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(gb_entry_t),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // Fullness is judged on the registered level, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/gb_instr_feeder.sv
// Buffers instruction/operand pairs and issues them to gbprocessor as
// single-cycle valid pulses separated by ISSUE_GAP idle cycles.
module gb_instr_feeder
  import gb_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 0,
  parameter int CNT_W     = 16,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_instruction,
  input  logic [7:0]       in_data,
  input  logic             enable,
  output logic [7:0]       instruction,
  output logic [7:0]       data,
  output logic             valid,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] issued_count
);

  localparam logic [7:0] GAP_LOAD = (ISSUE_GAP == 0) ? 8'd0 : 8'(ISSUE_GAP - 1);

  gb_entry_t     w_wr_entry;
  gb_entry_t     w_rd_entry;
  logic          w_full;
  logic          w_empty;
  logic          w_can_issue;
  logic          w_issue;
  feeder_state_e r_state;
  feeder_state_e w_state_nxt;
  logic [7:0]    r_gap;
  logic [7:0]    w_gap_nxt;
  logic          r_valid;
  logic [7:0]    r_instr;
  logic [7:0]    r_data;
  logic [CNT_W-1:0] r_cnt;

  assign w_wr_entry = '{instruction: in_instruction, data: in_data};
  assign in_ready   = !w_full;

  gb_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(gb_entry_t))
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (in_valid),
    .i_pop   (w_issue),
    .i_wdata (w_wr_entry),
    .o_rdata (w_rd_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  assign w_can_issue = enable && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_issue) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // With no gap this cycle doubles as an IDLE decision, giving one issue per cycle.
        if (ISSUE_GAP == 0) begin
          w_issue     = w_can_issue;
          w_state_nxt = w_can_issue ? ST_ISSUE : ST_IDLE;
        end else begin
          w_gap_nxt   = GAP_LOAD;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap == 8'd0) w_state_nxt = ST_IDLE;
        else               w_gap_nxt   = r_gap - 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_gap   <= 8'd0;
      r_valid <= 1'b0;
      r_instr <= 8'h00;
      r_data  <= 8'h00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_valid <= w_issue;
      if (w_issue) begin
        r_instr <= w_rd_entry.instruction;
        r_data  <= w_rd_entry.data;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign valid        = r_valid;
  assign instruction  = r_instr;
  assign data         = r_data;
  assign issued_count = r_cnt;

endmodule

// File: tb/tb_gb_instr_feeder.sv
// Directed bench for gb_instr_feeder: a gap-free instance and an ISSUE_GAP=3
// instance, each with its own producer signals and issue monitor.
module tb_gb_instr_feeder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       v0 = 1'b0, en0 = 1'b0;
  logic [7:0] ins0 = 8'h00, dat0 = 8'h00;
  logic       rdy0, ov0;
  logic [7:0] oi0, od0;
  logic [3:0] lv0;
  logic [15:0] cnt0;

  logic       v3 = 1'b0, en3 = 1'b0;
  logic [7:0] ins3 = 8'h00, dat3 = 8'h00;
  logic       rdy3, ov3;
  logic [7:0] oi3, od3;
  logic [3:0] lv3;
  logic [15:0] cnt3;

  gb_instr_feeder #(.DEPTH(8), .ISSUE_GAP(0), .CNT_W(16)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(v0), .in_ready(rdy0),
    .in_instruction(ins0), .in_data(dat0), .enable(en0),
    .instruction(oi0), .data(od0), .valid(ov0), .level(lv0), .issued_count(cnt0)
  );

  gb_instr_feeder #(.DEPTH(8), .ISSUE_GAP(3), .CNT_W(16)) u_dut3 (
    .clock(clock), .reset(reset), .in_valid(v3), .in_ready(rdy3),
    .in_instruction(ins3), .in_data(dat3), .enable(en3),
    .instruction(oi3), .data(od3), .valid(ov3), .level(lv3), .issued_count(cnt3)
  );

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  logic [15:0] q0[$];
  logic [15:0] q3[$];
  int          c3[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && ov0) q0.push_back({oi0, od0});
    if (!reset && ov3) begin
      q3.push_back({oi3, od3});
      c3.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [7:0] ins;
    logic [7:0] dat;
    logic       rdy;
    logic [3:0] lvl;
  } fill_vec_t;

  fill_vec_t  fv[9];
  logic [7:0] gv[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [15:0] e16;

    // ALU ops on each register; the 9th push must be refused while full.
    fv[0] = '{8'h80, 8'h01, 1'b1, 4'd1};
    fv[1] = '{8'h89, 8'h12, 1'b1, 4'd2};
    fv[2] = '{8'h92, 8'h23, 1'b1, 4'd3};
    fv[3] = '{8'h9B, 8'h34, 1'b1, 4'd4};
    fv[4] = '{8'hA4, 8'h45, 1'b1, 4'd5};
    fv[5] = '{8'hAD, 8'h56, 1'b1, 4'd6};
    fv[6] = '{8'hB6, 8'h67, 1'b1, 4'd7};
    fv[7] = '{8'hBF, 8'h78, 1'b1, 4'd8};
    fv[8] = '{8'h87, 8'h89, 1'b0, 4'd8};
    gv[0] = 8'h98; gv[1] = 8'hA9; gv[2] = 8'hBF; gv[3] = 8'h93;

    // reset then idle
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", ov0, 1'b0);
    chk("rst_instr", oi0, 8'h00);
    chk("rst_data", od0, 8'h00);
    chk("rst_level", lv0, 4'd0);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_count", cnt0, 16'd0);
    en0 = 1'b1;
    repeat (20) tick();
    chk("idle_no_valid", q0.size(), 0);

    // single entry latency
    ins0 = 8'hAB; dat0 = 8'h5A; v0 = 1'b1;
    tick();
    v0 = 1'b0;
    chk("lat_not_early", ov0, 1'b0);
    chk("lat_level1", lv0, 4'd1);
    tick();
    chk("lat_valid", ov0, 1'b1);
    chk("lat_instr", oi0, 8'hAB);
    chk("lat_data", od0, 8'h5A);
    chk("lat_count", cnt0, 16'd1);
    chk("lat_level0", lv0, 4'd0);
    tick();
    chk("pulse_one_cycle", ov0, 1'b0);
    chk("hold_instr", oi0, 8'hAB);
    chk("hold_data", od0, 8'h5A);
    q0.delete();

    // fill / full with enable low, then drain in order
    en0 = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      ins0 = fv[i].ins; dat0 = fv[i].dat; v0 = 1'b1;
      chk($sformatf("fill_ready_%0d", i), rdy0, fv[i].rdy);
      tick();
      chk($sformatf("fill_level_%0d", i), lv0, fv[i].lvl);
    end
    chk("fill_no_issue", q0.size(), 0);
    en0 = 1'b1;
    w = 0;
    while (!rdy0 && w < 10) begin tick(); w++; end
    chk("refill_ready", rdy0, 1'b1);
    chk("refill_level", lv0, 4'd7);
    tick();
    v0 = 1'b0;
    w = 0;
    while (q0.size() < 9 && w < 40) begin tick(); w++; end
    chk("drain_size", q0.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < q0.size()) chk($sformatf("drain_order_%0d", i), q0[i], {fv[i].ins, fv[i].dat});
    chk("drain_count", cnt0, 16'd10);
    chk("drain_level", lv0, 4'd0);

    // gap spacing on the ISSUE_GAP=3 instance
    en3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v3 = 1'b1; ins3 = gv[i]; dat3 = 8'h30 + 8'(i);
      tick();
    end
    v3 = 1'b0;
    w = 0;
    while (q3.size() < 4 && w < 60) begin tick(); w++; end
    chk("gap_size", q3.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q3.size()) chk($sformatf("gap_order_%0d", i), q3[i], {gv[i], 8'h30 + 8'(i)});
    for (int i = 1; i < 4; i++)
      if (i < c3.size()) chk($sformatf("gap_spacing_%0d", i), c3[i] - c3[i-1], 5);
    chk("gap_count", cnt3, 16'd4);
    repeat (8) tick();

    // pause / resume on the gap-free instance
    q0.delete();
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          int wp;
          v0 = 1'b1; ins0 = 8'h20 + 8'(k); dat0 = 8'hC0 + 8'(k);
          wp = 0;
          while (!rdy0 && wp < 50) begin tick(); wp++; end
          tick();
        end
        v0 = 1'b0;
      end
      begin
        int wc;
        wc = 0;
        while (q0.size() < 3 && wc < 100) begin @(negedge clock); #1; wc++; end
        en0 = 1'b0;
        repeat (4) tick();
        chk("pause_no_issue", q0.size(), 3);
        en0 = 1'b1;
      end
    join
    w = 0;
    while (q0.size() < 10 && w < 60) begin tick(); w++; end
    chk("resume_size", q0.size(), 10);
    for (int k = 0; k < 10; k++) begin
      e16 = {8'h20 + 8'(k), 8'hC0 + 8'(k)};
      if (k < q0.size()) chk($sformatf("resume_order_%0d", k), q0[k], e16);
    end
    chk("resume_count", cnt0, 16'd20);

    // reset mid-stream while the gap instance sits in GAP with 5 buffered
    for (int i = 0; i < 7; i++) begin
      v3 = 1'b1; ins3 = 8'h80 + 8'(i); dat3 = 8'h70 + 8'(i);
      tick();
    end
    v3 = 1'b0;
    tick();
    chk("pre_rst_level", lv3, 4'd5);
    chk("pre_rst_count", cnt3, 16'd6);
    chk("pre_rst_valid", ov3, 1'b0);
    reset = 1'b1; v3 = 1'b1; ins3 = 8'hFF; dat3 = 8'hFF;
    tick();
    reset = 1'b0; v3 = 1'b0;
    chk("mid_rst_level", lv3, 4'd0);
    chk("mid_rst_valid", ov3, 1'b0);
    chk("mid_rst_count", cnt3, 16'd0);
    chk("mid_rst_instr", oi3, 8'h00);
    chk("mid_rst_ready", rdy3, 1'b1);
    q3.delete();
    ins3 = 8'h9B; dat3 = 8'hE1; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("post_rst_not_early", ov3, 1'b0);
    tick();
    chk("post_rst_valid", ov3, 1'b1);
    chk("post_rst_instr", oi3, 8'h9B);
    chk("post_rst_data", od3, 8'hE1);
    chk("post_rst_count", cnt3, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
